// File: rtl/demux8_loader.sv
// Eight-byte register bank that is loaded either one byte at a time by address,
// or as a sequential burst into r0..r7 that starts with a start pulse.
module demux8_loader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] din,
    input  logic [2:0] wr_sel,
    output logic [7:0] r0,
    output logic [7:0] r1,
    output logic [7:0] r2,
    output logic [7:0] r3,
    output logic [7:0] r4,
    output logic [7:0] r5,
    output logic [7:0] r6,
    output logic [7:0] r7,
    output logic [7:0] valid_mask,
    output logic       full,
    output logic       busy,
    output logic       done,
    output logic [2:0] wr_ptr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] bank [8];
    logic       accept;
    logic [2:0] wr_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = FILL;
                FILL:    if (in_valid && (wr_ptr == 3'd7)) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // in_ready is the only output allowed to look at inputs; start and clear both block acceptance
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    in_ready = !clear && !start;
            FILL:    begin
                in_ready = !clear;
                busy     = 1'b1;
            end
            DONE:    done = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign wr_idx = (state == FILL) ? wr_ptr : wr_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank       <= '{default: 8'h00};
            valid_mask <= 8'h00;
        end else if (clear) begin
            bank       <= '{default: 8'h00};
            valid_mask <= 8'h00;
        end else if (accept) begin
            bank[wr_idx]       <= din;
            valid_mask[wr_idx] <= 1'b1;
        end
    end

    // Incrementing past index 7 wraps naturally to 0 as the burst completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 3'd0;
        end else if (clear) begin
            wr_ptr <= 3'd0;
        end else if ((state == IDLE) && start) begin
            wr_ptr <= 3'd0;
        end else if ((state == FILL) && accept) begin
            wr_ptr <= wr_ptr + 3'd1;
        end
    end

    assign full = &valid_mask;
    assign r0   = bank[0];
    assign r1   = bank[1];
    assign r2   = bank[2];
    assign r3   = bank[3];
    assign r4   = bank[4];
    assign r5   = bank[5];
    assign r6   = bank[6];
    assign r7   = bank[7];

endmodule

// File: tb/tb_demux8_loader.sv
// Randomised scoreboard bench for demux8_loader: a byte-level reference model predicts
// the bank contents and status after every edge, and a monitor compares them.
module tb_demux8_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic [2:0] wr_sel;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [7:0] valid_mask;
    logic       full;
    logic       busy;
    logic       done;
    logic [2:0] wr_ptr;

    typedef struct packed {
        logic [63:0] bank;
        logic [7:0]  mask;
        logic        full;
        logic        busy;
        logic        done;
        logic [2:0]  ptr;
    } expect_t;

    expect_t    sb_q[$];
    int         n_checks = 0;
    int         n_fails  = 0;

    // Reference model: plain bytes plus "burst in progress" bookkeeping
    logic [7:0] m_bank [8];
    logic [7:0] m_mask;
    logic       m_filling;
    logic       m_done;
    int         m_count;

    demux8_loader dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .din(din), .wr_sel(wr_sel),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .valid_mask(valid_mask), .full(full), .busy(busy), .done(done), .wr_ptr(wr_ptr)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dut_bank();
        return {r7, r6, r5, r4, r3, r2, r1, r0};
    endfunction

    function automatic expect_t model_snapshot();
        expect_t e;
        for (int i = 0; i < 8; i++) e.bank[i*8 +: 8] = m_bank[i];
        e.mask = m_mask;
        e.full = (m_mask == 8'hFF);
        e.busy = m_filling;
        e.done = m_done;
        e.ptr  = 3'(m_count);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
        m_mask    = 8'h00;
        m_filling = 1'b0;
        m_done    = 1'b0;
        m_count   = 0;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " bank"}, dut_bank(), 64'h0);
        checkOutput({tag, " valid_mask"}, {56'h0, valid_mask}, 64'h0);
        checkOutput({tag, " busy"}, {63'h0, busy}, 64'h0);
        checkOutput({tag, " done"}, {63'h0, done}, 64'h0);
        checkOutput({tag, " wr_ptr"}, {61'h0, wr_ptr}, 64'h0);
    endtask

    // Drive one cycle of inputs, check in_ready, advance the model, queue the post-edge expectation
    task automatic applyStimulus(input logic clr, input logic st, input logic vld,
                                 input logic [7:0] d, input logic [2:0] sel);
        logic exp_ready;
        @(negedge clk);
        clear    = clr;
        start    = st;
        in_valid = vld;
        din      = d;
        wr_sel   = sel;
        #1;
        exp_ready = !clr && (m_filling || (!m_done && !st));
        checkOutput("in_ready", {63'h0, in_ready}, {63'h0, exp_ready});
        if (clr) begin
            model_reset();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_filling) begin
            if (vld) begin
                m_bank[m_count]  = d;
                m_mask[m_count]  = 1'b1;
                if (m_count == 7) begin
                    m_count   = 0;
                    m_filling = 1'b0;
                    m_done    = 1'b1;
                end else begin
                    m_count++;
                end
            end
        end else if (st) begin
            m_filling = 1'b1;
            m_count   = 0;
        end else if (vld) begin
            m_bank[sel] = d;
            m_mask[sel] = 1'b1;
        end
        sb_q.push_back(model_snapshot());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 3'($urandom));
    endtask

    task automatic burst(input logic [7:0] base, input bit bubbles);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, base + 8'(i), 3'($urandom));
            if (bubbles) applyStimulus(1'b0, 1'b0, 1'b0, 8'hEE, 3'($urandom));
        end
    endtask

    // Async reset asserted between edges while a burst is in flight
    task automatic async_reset_mid_cycle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: each edge that has a queued expectation is compared once outputs settle
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("bank", dut_bank(), e.bank);
                checkOutput("valid_mask", {56'h0, valid_mask}, {56'h0, e.mask});
                checkOutput("full", {63'h0, full}, {63'h0, e.full});
                checkOutput("busy", {63'h0, busy}, {63'h0, e.busy});
                checkOutput("done", {63'h0, done}, {63'h0, e.done});
                checkOutput("wr_ptr", {61'h0, wr_ptr}, {61'h0, e.ptr});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        din      = 8'h00;
        wr_sel   = 3'd0;
        model_reset();
        #2;
        check_all_zero("reset");
        rst_n = 1'b1;

        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5, 3'd5);
        idle_cycles(2);

        burst(8'h10, 1'b0);
        idle_cycles(2);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
        burst(8'h10, 1'b1);
        idle_cycles(2);

        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, 3'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h30 + 8'(i), 3'd7);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h99, 3'd2);
        idle_cycles(2);
        burst(8'h40, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h55, 3'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h66, 3'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h77, 3'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h88, 3'd3);

        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC1, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC2, 3'd0);
        async_reset_mid_cycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A, 3'd3);
        idle_cycles(1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 1) == 1), 8'($urandom), 3'($urandom));
        end
        idle_cycles(2);

        @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/demux8_loader.md
DEMUX8_LOADER -- requirements
Module: demux8_loader

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of bank, mask and FSM.
- start  in  1  begins a sequential fill (burst) of r0..r7.
- in_valid  in  1  data byte offered.
- in_ready  out  1  block can accept a byte this cycle.
- din  in  8  data byte.
- wr_sel  in  3  target register index in addressed mode.
- r0..r7  out  8 each  registered bank outputs; r0 is index 0, r7 is index 7.
- valid_mask  out  8  bit i set once ri has been written since the last clear or reset.
- full  out  1  equals the AND of all valid_mask bits.
- busy  out  1  high in FILL.
- done  out  1  one-cycle pulse in DONE.
- wr_ptr  out  3  current fill index.
REQ-002 The block SHALL have no parameters; every width is fixed as listed.

Function
REQ-003 A byte SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1.
REQ-004 The FSM SHALL have exactly three states: IDLE, FILL and DONE.
REQ-005 In IDLE, in_ready SHALL be 1 except when start=1; if start=1, in_ready SHALL be 0.
REQ-006 In FILL, in_ready SHALL be 1.
REQ-007 In DONE, in_ready SHALL be 0.
REQ-008 Addressed mode: in IDLE, an accepted byte SHALL be written to r[wr_sel] at that edge, and valid_mask[wr_sel] SHALL be set.
REQ-009 IDLE SHALL go to FILL on start=1, and wr_ptr SHALL be loaded with 0.
REQ-010 IDLE with start=1 and in_valid=1 in the same cycle SHALL write nothing.
REQ-011 Fill mode: in FILL, an accepted byte SHALL be written to r[wr_ptr], and valid_mask[wr_ptr] SHALL be set.
REQ-012 After a FILL write, wr_ptr SHALL increment by 1; wr_sel SHALL be ignored in FILL.
REQ-013 FILL SHALL go to DONE on the edge that accepts the byte for index 7, and wr_ptr SHALL wrap to 0.
REQ-014 FILL SHALL hold state and wr_ptr in any cycle where in_valid=0; bubbles are allowed without limit.
REQ-015 DONE SHALL last exactly one cycle and then go to IDLE; done SHALL be 1 only in DONE.
REQ-016 start SHALL be ignored in FILL and in DONE.
REQ-017 clear=1 SHALL, at the next edge and from any state, set r0..r7 to 0x00, valid_mask to 0x00 and wr_ptr to 0, and set the state to IDLE.
REQ-018 clear SHALL take priority over start and over any byte acceptance in the same cycle.
REQ-019 in_ready SHALL be 0 while clear=1.
REQ-020 A clear during FILL SHALL abort the fill; done SHALL NOT pulse for that fill.
REQ-021 Bank registers not being written SHALL hold their values; rewriting an already-valid index SHALL overwrite it and leave the mask bit set.
REQ-022 busy, done, full, valid_mask, wr_ptr and r0..r7 SHALL be driven directly from registers or from state decode; in_ready is the only output that may depend combinationally on inputs (start, clear).
REQ-023 Write latency SHALL be one cycle: a byte accepted at edge N SHALL be visible on its ri output after edge N.

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock, force state=IDLE, r0..r7=0x00, valid_mask=0x00, wr_ptr=0, done=0 and busy=0.
REQ-025 Assertion of rst_n mid-FILL SHALL abandon the fill with no done pulse.
REQ-026 After deassertion, the first accepting edge SHALL behave exactly as in IDLE.

Verification
REQ-027 Addressed write: IDLE, wr_sel=5, din=0xA5, in_valid=1 for 1 cycle -> r5=0xA5, valid_mask=0x20, other ri stay 0x00.
REQ-028 Burst, no gaps: start pulse, then bytes 0x10..0x17 back-to-back -> r0..r7=0x10..0x17, done high exactly 1 cycle after the 8th accept, full=1, in_ready=0 in DONE.
REQ-029 Burst with bubbles: in_valid toggling 1,0,1,0... during FILL -> wr_ptr advances only on accepts, final contents identical to REQ-028, busy high throughout.
REQ-030 Start/valid collision: IDLE with start=1, in_valid=1, din=0xFF, wr_sel=0 -> in_ready=0, r0 unchanged, next state FILL with wr_ptr=0.
REQ-031 Clear mid-fill: clear=1 after 3 of 8 fill bytes -> all ri=0x00, valid_mask=0x00, IDLE, no done pulse; the next start restarts at index 0.
REQ-032 Async reset: rst_n=0 between clock edges during FILL -> outputs read 0 before the next edge, state IDLE.
